// File: rtl/psum_acc_if.sv
// Stream bundle for psum_acc: psum input handshake and result output handshake.
// The slave modport is the accumulator side; the master modport is the producer/consumer side.
interface psum_acc_if #(
  parameter int psum_bw = 10,
  parameter int acc_bw  = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [psum_bw-1:0] in_psum;
  logic               out_valid;
  logic               out_ready;
  logic [acc_bw-1:0]  out_data;

  modport master (
    output in_valid, in_psum, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_psum, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/psum_acc.sv
// Saturating accumulator summing a programmed number of mac partial sums per run.
// Optional PSUM_ACC_RELU_EN clamps negative final results to zero in out_data.
module psum_acc #(
  parameter int psum_bw = 10,
  parameter int acc_bw  = 16,
  parameter int cnt_bw  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [cnt_bw-1:0] len,
  psum_acc_if.slave         bus,
  output logic              busy,
  output logic              sat_flag
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  localparam logic [acc_bw-1:0] ACC_MAX = {1'b0, {(acc_bw-1){1'b1}}};
  localparam logic [acc_bw-1:0] ACC_MIN = {1'b1, {(acc_bw-1){1'b0}}};

  state_t            state_q;
  logic [acc_bw-1:0] acc_q, acc_d;
  logic [cnt_bw-1:0] cnt_q, cnt_d;
  logic [cnt_bw-1:0] len_q;
  logic [acc_bw-1:0] out_data_q, result_d;
  logic              out_valid_q;
  logic              in_ready_q;
  logic              busy_q;
  logic              sat_q, sat_d;

  logic [acc_bw:0]   sum;
  logic              ovf_pos, ovf_neg;
  logic              accept, last_beat;

  // One guard bit above the accumulator exposes overflow in the top two sum bits.
  always_comb begin
    sum       = {acc_q[acc_bw-1], acc_q}
              + {{(acc_bw+1-psum_bw){bus.in_psum[psum_bw-1]}}, bus.in_psum};
    ovf_pos   = ~sum[acc_bw] &  sum[acc_bw-1];
    ovf_neg   =  sum[acc_bw] & ~sum[acc_bw-1];
    acc_d     = ovf_pos ? ACC_MAX : (ovf_neg ? ACC_MIN : sum[acc_bw-1:0]);
    sat_d     = sat_q | ovf_pos | ovf_neg;
    cnt_d     = cnt_q + cnt_bw'(1);
    accept    = bus.in_valid & in_ready_q;
    last_beat = (cnt_d == len_q);
`ifdef PSUM_ACC_RELU_EN
    result_d  = acc_d[acc_bw-1] ? '0 : acc_d;
`else
    result_d  = acc_d;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && (len != '0)) begin
            len_q      <= len;
            acc_q      <= '0;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ACC;
          end
        end
        ACC: begin
          if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            sat_q <= sat_d;
            if (last_beat) begin
              out_data_q  <= result_d;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
              state_q     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = busy_q;
  assign sat_flag      = sat_q;

endmodule

// File: tb/tb_psum_acc.sv
// Scoreboard bench for psum_acc: expected results are queued per run from an
// arithmetic reference and checked by an independent output monitor.
module tb_psum_acc;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] len;
  logic       busy;
  logic       sat_flag;

  psum_acc_if #(.psum_bw(10), .acc_bw(16)) bus ();

  psum_acc #(.psum_bw(10), .acc_bw(16), .cnt_bw(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .bus      (bus),
    .busy     (busy),
    .sat_flag (sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    bit sat;
  } exp_t;

  exp_t exp_q[$];
  int   pq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer sum, clamped to 16-bit signed range after every add.
  function automatic exp_t model();
    exp_t r;
    int   a = 0;
    bit   s = 0;
    foreach (pq[j]) begin
      a += pq[j];
      if (a > 32767) begin a = 32767; s = 1; end
      else if (a < -32768) begin a = -32768; s = 1; end
    end
`ifdef PSUM_ACC_RELU_EN
    if (a < 0) a = 0;
`endif
    r.data = a;
    r.sat  = s;
    return r;
  endfunction

  // Monitor: every cycle a result is presented it must match the queue head.
  always @(negedge clk) begin
    if (!reset && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got %0d expected none", $signed(bus.out_data));
      end else begin
        check("out_data", $signed(bus.out_data), exp_q[0].data);
        if (bus.out_ready) begin
          check("sat_flag_xfer", sat_flag, exp_q[0].sat);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  function automatic int rand_psum();
    return int'($urandom_range(1023)) - 512;
  endfunction

  // Entered and left at posedge+1; pq holds the run's psums.
  task automatic do_run(input int gap_pct, input int hold_cyc);
    int   n = pq.size();
    int   i = 0;
    int   guard = 0;
    exp_t e = model();
    exp_q.push_back(e);
    start        = 1'b1;
    len          = 8'(n);
    bus.in_valid = 1'b1;
    bus.in_psum  = 10'(rand_psum());
    @(posedge clk); #1;
    start = 1'b0;
    while (i < n && guard < 20000) begin
      bus.in_valid = ($urandom_range(99) >= gap_pct);
      bus.in_psum  = 10'(pq[i]);
      @(negedge clk);
      check("in_ready_acc", bus.in_ready, 1);
      check("busy_acc", busy, 1);
      @(posedge clk); #1;
      if (bus.in_valid) i++;
      guard++;
    end
    if (guard >= 20000) check("run_timeout", guard, 0);
    bus.in_valid = 1'b1;
    bus.in_psum  = 10'(rand_psum());
    @(negedge clk);
    check("out_valid_latency", bus.out_valid, 1);
    check("in_ready_hold", bus.in_ready, 0);
    repeat (hold_cyc) begin
      @(posedge clk); #1;
      start = 1'(($urandom_range(1)));
      len   = 8'($urandom_range(1, 9));
      @(negedge clk);
      check("in_ready_hold", bus.in_ready, 0);
      check("out_valid_hold", bus.out_valid, 1);
      check("busy_hold", busy, 1);
    end
    @(posedge clk); #1;
    start         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("out_valid_after_xfer", bus.out_valid, 0);
    check("busy_after_xfer", busy, 0);
    check("sat_flag_idle", sat_flag, e.sat);
    @(posedge clk); #1;
  endtask

  initial begin
    int saved[$];
    reset         = 1'b1;
    start         = 1'b0;
    len           = '0;
    bus.in_valid  = 1'b0;
    bus.in_psum   = '0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_sat", sat_flag, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a len=5 run after two accepted beats
    start = 1'b1; len = 8'd5;
    @(posedge clk); #1;
    start = 1'b0; bus.in_valid = 1'b1; bus.in_psum = 10'd100;
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_data", bus.out_data, 0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    pq = '{3, -7, 100, 511};
    do_run(0, 5);
    pq = {};
    repeat (100) pq.push_back(511);
    do_run(0, 1);
    pq = {};
    repeat (70) pq.push_back(-512);
    do_run(0, 0);
    pq = '{-5, -5, -5};
    do_run(0, 2);

    // len=0 start is ignored
    start = 1'b1; len = 8'd0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    check("len0_in_ready", bus.in_ready, 0);
    check("len0_busy", busy, 0);
    @(posedge clk); #1;

    pq = '{-300};
    do_run(0, 1);

    // Same data gapless and gapped
    pq = {};
    repeat (20) pq.push_back(rand_psum());
    saved = pq;
    do_run(0, 1);
    pq = saved;
    do_run(50, 1);

    for (int r = 0; r < 25; r++) begin
      int n = int'($urandom_range(1, 60));
      pq = {};
      for (int k = 0; k < n; k++)
        pq.push_back(($urandom_range(3) == 0) ? 511 : rand_psum());
      do_run(int'($urandom_range(60)), int'($urandom_range(4)));
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
